// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction between EX and WB, waits for
// the data-bus response of its load/store, aligns load data and drops stale responses.
module mem_stage (
   input  logic        clk,
   input  logic        resetn,
   input  logic        es_to_ms_valid,
   output logic        ms_allowin,
   input  logic [31:0] es_pc,
   input  logic        es_rf_we,
   input  logic [4:0]  es_rf_waddr,
   input  logic [31:0] es_alu_result,
   input  logic        es_mem_req,
   input  logic [4:0]  es_ld_op,
   input  logic [15:0] es_except,
   input  logic        data_sram_data_ok,
   input  logic [31:0] data_sram_rdata,
   input  logic        ws_allowin,
   input  logic        wb_flush,
   output logic        ms_to_ws_valid,
   output logic [31:0] ms_pc,
   output logic [37:0] ms_rf_collect,
   output logic [15:0] ms_except,
   output logic [37:0] ms_fwd,
   output logic        ms_ld_pending,
   output logic        ms_ex_pending
);

   // WAIT means a request is outstanding; READY covers "no request" and "data captured".
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_WAIT  = 2'd1,
      S_READY = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] pc_q;
   logic        rf_we_q;
   logic [4:0]  waddr_q;
   logic [31:0] alu_q;
   logic [4:0]  ld_op_q;
   logic [15:0] except_q;
   logic [31:0] rdata_buf;
   logic [1:0]  drop_cnt;

   logic        ms_valid;
   logic        waiting;
   logic        drop_idle;
   logic        data_hit;
   logic        ms_ready_go;
   logic        flush_inc;
   logic        drop_dec;
   logic        rf_we_out;
   logic [31:0] ld_word;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;
   logic [31:0] wdata;

   assign ms_valid    = (state != S_EMPTY);
   assign waiting     = (state == S_WAIT);
   assign drop_idle   = (drop_cnt == 2'd0);
   assign data_hit    = data_sram_data_ok & drop_idle;
   assign ms_ready_go = ~waiting | data_hit;
   assign ms_allowin  = ~ms_valid | (ms_ready_go & ws_allowin);

   // A response arriving in the flush cycle is consumed by the flushed load, so it owes nothing.
   assign flush_inc = wb_flush & waiting & ~data_hit;
   assign drop_dec  = data_sram_data_ok & ~drop_idle;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         drop_cnt <= 2'd0;
      end else if (flush_inc && !drop_dec && drop_cnt != 2'd3) begin
         drop_cnt <= drop_cnt + 2'd1;
      end else if (drop_dec && !flush_inc) begin
         drop_cnt <= drop_cnt - 2'd1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= S_EMPTY;
         pc_q      <= 32'd0;
         rf_we_q   <= 1'b0;
         waddr_q   <= 5'd0;
         alu_q     <= 32'd0;
         ld_op_q   <= 5'd0;
         except_q  <= 16'd0;
         rdata_buf <= 32'd0;
      end else if (wb_flush) begin
         state <= S_EMPTY;
      end else begin
         if (waiting && data_hit) begin
            state     <= S_READY;
            rdata_buf <= data_sram_rdata;
         end
         if (ms_allowin) begin
            if (es_to_ms_valid) begin
               state    <= es_mem_req ? S_WAIT : S_READY;
               pc_q     <= es_pc;
               rf_we_q  <= es_rf_we;
               waddr_q  <= es_rf_waddr;
               alu_q    <= es_alu_result;
               ld_op_q  <= es_ld_op;
               except_q <= es_except;
            end else begin
               state <= S_EMPTY;
            end
         end
      end
   end

   // In the response cycle the bus data is used directly; afterwards the buffered copy.
   always_comb begin
      ld_word = waiting ? data_sram_rdata : rdata_buf;
      case (alu_q[1:0])
         2'd0:    ld_byte = ld_word[7:0];
         2'd1:    ld_byte = ld_word[15:8];
         2'd2:    ld_byte = ld_word[23:16];
         default: ld_byte = ld_word[31:24];
      endcase
      ld_half = alu_q[1] ? ld_word[31:16] : ld_word[15:0];
      if (ld_op_q[0]) begin
         ld_data = {{24{ld_byte[7]}}, ld_byte};
      end else if (ld_op_q[1]) begin
         ld_data = {24'd0, ld_byte};
      end else if (ld_op_q[2]) begin
         ld_data = {{16{ld_half[15]}}, ld_half};
      end else if (ld_op_q[3]) begin
         ld_data = {16'd0, ld_half};
      end else begin
         ld_data = ld_word;
      end
      wdata = (|ld_op_q) ? ld_data : alu_q;
   end

   assign rf_we_out      = ms_valid & rf_we_q & ~(|except_q);
   assign ms_to_ws_valid = ms_valid & ms_ready_go;
   assign ms_pc          = pc_q;
   assign ms_except      = except_q;
   assign ms_rf_collect  = {rf_we_out, waddr_q, wdata};
   assign ms_fwd         = {ms_valid & rf_we_q, waddr_q, wdata};
   assign ms_ld_pending  = ms_valid & (|ld_op_q) & ~ms_ready_go;
   assign ms_ex_pending  = ms_valid & (|except_q);

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between EX and WBreg. Holds one instruction, waits for the data-bus `data_ok` of any load/store issued from EX, aligns and sign/zero-extends load data, and presents `{we, waddr, wdata}`, PC and exception vector to WB. It also drives the forwarding/load-use bus back to ID and discards stale responses after a WB flush.

## Interface
- No parameters; all widths fixed.
- `clk`  in  1  sole clock, rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `es_to_ms_valid`  in  1  EX holds a valid instruction for MEM.
- `ms_allowin`  out  1  MEM accepts an instruction this cycle.
- `es_pc`  in  32  PC of the incoming instruction.
- `es_rf_we`, `es_rf_waddr`  in  1, 5  register-file write enable and address.
- `es_alu_result`  in  32  ALU result; effective address for loads/stores.
- `es_mem_req`  in  1  EX issued a data request that got `addr_ok`.
- `es_ld_op`  in  5  one-hot `{w, hu, h, bu, b}`; all zero means not a load.
- `es_except`  in  16  exception vector; passed through unchanged.
- `data_sram_data_ok`  in  1  in-order data-bus response strobe.
- `data_sram_rdata`  in  32  response data, valid with `data_ok`.
- `ws_allowin`  in  1  WB accepts.
- `wb_flush`  in  1  WB exception, ertn or refetch flush.
- `ms_to_ws_valid`  out  1  valid instruction for WB.
- `ms_pc`  out  32  registered PC.
- `ms_rf_collect`  out  38  `{we, waddr[4:0], wdata[31:0]}`.
- `ms_except`  out  16  registered exception vector.
- `ms_fwd`  out  38  `{ms_valid & we, waddr, wdata}` for ID bypass.
- `ms_ld_pending`  out  1  valid load whose data has not yet arrived; ID stalls on a matching source.
- `ms_ex_pending`  out  1  `ms_valid & (|ms_except)`; EX uses it to suppress new stores.

## Operation
- States:
  - EMPTY: `ms_valid=0`.
  - WAIT: valid, `mem_req` set, data not yet seen.
  - READY: valid, with no request or with data captured.
- Accept rule: on `es_to_ms_valid & ms_allowin`, latch pc, rf fields, alu_result, mem_req, ld_op and except. Next state is WAIT if `es_mem_req`, otherwise READY. If nothing new is accepted while `ms_allowin`, go to EMPTY.
- `ms_ready_go = ~mem_req | data_seen | (data_ok & drop_cnt==0)`.
- `ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin)`.
- `ms_to_ws_valid = ms_valid & ms_ready_go`.
- WAIT→READY: on `data_ok` with `drop_cnt==0`, capture `rdata` into `rdata_buf` and set `data_seen`. Load wdata takes `data_sram_rdata` directly in the `data_ok` cycle and `rdata_buf` after it.
- Load alignment: `off = alu_result[1:0]`.
  - b/bu: byte `off`, sign- or zero-extended.
  - h/hu: halfword `off[1]`, sign- or zero-extended.
  - w: full word.
  - Non-load: `wdata = alu_result`.
- `ms_rf_collect.we = ms_valid & rf_we & ~(|ms_except)`.
- Flush: `wb_flush` sets `ms_valid` to 0 next edge, takes priority over accept, and clears `data_seen`. If the occupant was in WAIT, `drop_cnt` increments.
- Drop counter: 2 bits, saturating at 3. Any `data_ok` while `drop_cnt!=0` decrements it and is never delivered to an instruction.
  - Simultaneous flush-increment and drop-decrement leave the count unchanged.
  - A post-flush instruction in WAIT consumes only the first `data_ok` seen after `drop_cnt` reaches 0.
- `ms_ld_pending = ms_valid & (|ld_op) & ~ms_ready_go`.

## Timing
- Async reset values: `ms_valid=0`, `data_seen=0`, `drop_cnt=0`, all data registers 0. Consequently `ms_to_ws_valid=0`, `ms_allowin=1`, `ms_ld_pending=0` and `ms_ex_pending=0`.
- Latency is 1 cycle in MEM for non-memory instructions when `ws_allowin=1`.
- A memory op leaves in the `data_ok` cycle at the earliest, which can be the first cycle after entry.
- Back-to-back throughput is 1 instruction/cycle.
- `data_ok` while WB stalls: data is held in `rdata_buf`; the output stays stable until `ws_allowin`.
- Outputs are combinational from registers plus `data_ok`/`rdata`/`ws_allowin`. There is no combinational path from `es_*` to outputs.

## Test plan
- ALU op `pc=0x1c000000`, `alu=0x12345678`, `waddr=5`, `ws_allowin=1` → next cycle `ms_to_ws_valid=1`, `ms_rf_collect={1,5,0x12345678}`.
- `ld.b` addr `0x...3`, `rdata=0x80FF0011`, `data_ok` 3 cycles after entry → `ms_ld_pending=1` for 2 cycles, then `wdata=0xFFFFFF80`. `ld.hu` addr `0x...2`, same rdata → `wdata=0x000080FF`.
- Load with `data_ok` while `ws_allowin=0` for 2 cycles, bus rdata changed afterwards → `wdata` keeps the captured value and the instruction is handed over when `ws_allowin` rises.
- Load in WAIT, `wb_flush` pulse → `ms_valid=0`, `drop_cnt=1`. Then a new load enters; the first `data_ok` (`0xDEAD0000`) is discarded and the second (`0x00000042`) yields `wdata=0x42`.
- Instruction with `es_except[bit]=1`, `rf_we=1` → `ms_except` passed through, `ms_rf_collect.we=0`, `ms_ex_pending=1`.
- Assert `resetn` low mid-WAIT, then release → all outputs at reset values, `drop_cnt=0`.
